// File: rtl/tras_cmd_arbiter_if.sv
// Bundle of the shared transceiver command tap: per-requester command inputs on one side,
// the single tap toward the bit-level transceiver plus ownership status on the other.
interface tras_cmd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CSIZE   = 4
);
    logic [NUM_REQ-1:0]       req_busy;
    logic [NUM_REQ-1:0]       req_cmd_vld;
    logic [NUM_REQ*CSIZE-1:0] req_cmd;
    logic [NUM_REQ*4-1:0]     req_cmd_mid;
    logic [NUM_REQ*2-1:0]     req_cmd_proc_id;
    logic [NUM_REQ-1:0]       req_cmd_ready;
    logic [NUM_REQ-1:0]       grant;
    logic                     tras_cmd_vld;
    logic [CSIZE-1:0]         tras_cmd;
    logic                     tras_cmd_ready;
    logic [3:0]               curr_mid;
    logic [1:0]               curr_proc_id;
    logic                     hold_err;

    modport master (
        output req_busy, req_cmd_vld, req_cmd, req_cmd_mid, req_cmd_proc_id, tras_cmd_ready,
        input  req_cmd_ready, grant, tras_cmd_vld, tras_cmd, curr_mid, curr_proc_id, hold_err
    );

    modport slave (
        input  req_busy, req_cmd_vld, req_cmd, req_cmd_mid, req_cmd_proc_id, tras_cmd_ready,
        output req_cmd_ready, grant, tras_cmd_vld, tras_cmd, curr_mid, curr_proc_id, hold_err
    );
endinterface

// File: rtl/tras_cmd_arbiter.sv
// Round-robin owner of the transceiver command tap: a requester keeps the tap for its whole
// busy window, with a mandatory release gap and a hold watchdog that evicts stalled owners.
module tras_cmd_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int CSIZE    = 4,
    parameter int HOLD_MAX = 1024
) (
    input  logic              clock,
    input  logic              rst_n,
    tras_cmd_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [IDX_W-1:0]   own_q,      own_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [3:0]         mid_q,      mid_d;
    logic [1:0]         pid_q,      pid_d;
    logic               hold_err_q, hold_err_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] lockout_q,  lockout_d;

    logic [CSIZE-1:0]   cmd_arr [NUM_REQ];
    logic [3:0]         mid_arr [NUM_REQ];
    logic [1:0]         pid_arr [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] eligible;
    logic               in_own;
    logic               tap_vld;
    logic               handshake;
    logic               wd_expire;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   rr_next;
    int                 scan_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cmd_arr[gi]   = bus.req_cmd[gi*CSIZE +: CSIZE];
            assign mid_arr[gi]   = bus.req_cmd_mid[gi*4 +: 4];
            assign pid_arr[gi]   = bus.req_cmd_proc_id[gi*2 +: 2];
            assign req_ready[gi] = grant_q[gi] & bus.tras_cmd_ready & in_own;
        end
    endgenerate

    // The tap is gated by state, so a command left valid when busy falls is simply dropped.
    assign in_own    = (state_q == ST_OWN);
    assign tap_vld   = in_own & bus.req_cmd_vld[own_q];
    assign handshake = tap_vld & bus.tras_cmd_ready;
    assign wd_expire = (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) & ~handshake;
    assign eligible  = bus.req_busy & ~lockout_q;
    assign rr_next   = (own_q == IDX_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;

    // First eligible requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            cand = IDX_W'(scan_idx);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        own_d      = own_q;
        rr_ptr_d   = rr_ptr_q;
        mid_d      = mid_q;
        pid_d      = pid_q;
        hold_err_d = 1'b0;
        hold_cnt_d = hold_cnt_q;
        lockout_d  = lockout_q & bus.req_busy;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_OWN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    own_d            = win_idx;
                    mid_d            = mid_arr[win_idx];
                    pid_d            = pid_arr[win_idx];
                    hold_cnt_d       = '0;
                end
            end
            ST_OWN: begin
                hold_cnt_d = handshake ? '0 : hold_cnt_q + 1'b1;
                // A busy fall wins over a coinciding watchdog expiry: normal release.
                if (!bus.req_busy[own_q]) begin
                    state_d    = ST_REL;
                    grant_d    = '0;
                    rr_ptr_d   = rr_next;
                    hold_cnt_d = '0;
                end else if (wd_expire) begin
                    state_d          = ST_REL;
                    grant_d          = '0;
                    rr_ptr_d         = rr_next;
                    hold_cnt_d       = '0;
                    hold_err_d       = 1'b1;
                    lockout_d[own_q] = 1'b1;
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            own_q      <= '0;
            rr_ptr_q   <= '0;
            mid_q      <= '0;
            pid_q      <= '0;
            hold_err_q <= 1'b0;
            hold_cnt_q <= '0;
            lockout_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            own_q      <= own_d;
            rr_ptr_q   <= rr_ptr_d;
            mid_q      <= mid_d;
            pid_q      <= pid_d;
            hold_err_q <= hold_err_d;
            hold_cnt_q <= hold_cnt_d;
            lockout_q  <= lockout_d;
        end
    end

    assign bus.req_cmd_ready = req_ready;
    assign bus.grant         = grant_q;
    assign bus.tras_cmd_vld  = tap_vld;
    assign bus.tras_cmd      = in_own ? cmd_arr[own_q] : '0;
    assign bus.curr_mid      = mid_q;
    assign bus.curr_proc_id  = pid_q;
    assign bus.hold_err      = hold_err_q;
endmodule

// File: tb/tb_tras_cmd_arbiter.sv
// Directed bench for tras_cmd_arbiter: a vector table for a single-owner session plus
// hand-written sequences for reset, contention, wrap, watchdog and boundary cases.
module tb_tras_cmd_arbiter;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    always #5 clock = ~clock;

    tras_cmd_arbiter_if #(.NUM_REQ(4), .CSIZE(4)) bus ();

    tras_cmd_arbiter #(.NUM_REQ(4), .CSIZE(4), .HOLD_MAX(16)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  busy;
        logic [3:0]  vld;
        logic [15:0] cmd;
        logic        rdy;
        logic [3:0]  e_grant;
        logic        e_vld;
        logic [3:0]  e_cmd;
        logic [3:0]  e_rr;
        logic [3:0]  e_mid;
        logic [1:0]  e_pid;
    } vec_t;

    vec_t       tv [12];
    logic [3:0] order [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string nm);
        int n;
        n = 0;
        while (bus.grant == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(bus.grant), 32'(exp));
    endtask

    function automatic int oh2idx(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] g, prev_g;
        int zeros, ngr, hs, idx;

        // mid[i] = A+i, proc_id[i] = i
        bus.req_cmd_mid     = 16'hDCBA;
        bus.req_cmd_proc_id = 8'b11_10_01_00;
        bus.req_busy        = 4'hF;
        bus.req_cmd_vld     = 4'hF;
        bus.req_cmd         = 16'hFFFF;
        bus.tras_cmd_ready  = 1'b1;

        //            busy     vld      cmd      rdy   grant    vld  cmd   rr       mid    pid
        tv[0]  = '{4'b0010, 4'b0000, 16'hFFFF, 1'b0, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'h0, 2'd0};
        tv[1]  = '{4'b0010, 4'b0010, 16'hFF1F, 1'b0, 4'b0010, 1'b1, 4'h1, 4'b0000, 4'hB, 2'd1};
        tv[2]  = '{4'b0010, 4'b0010, 16'hFF1F, 1'b1, 4'b0010, 1'b1, 4'h1, 4'b0010, 4'hB, 2'd1};
        tv[3]  = '{4'b0010, 4'b1111, 16'hFF2F, 1'b0, 4'b0010, 1'b1, 4'h2, 4'b0000, 4'hB, 2'd1};
        tv[4]  = '{4'b0010, 4'b1111, 16'hFF2F, 1'b1, 4'b0010, 1'b1, 4'h2, 4'b0010, 4'hB, 2'd1};
        tv[5]  = '{4'b0010, 4'b0010, 16'h0030, 1'b1, 4'b0010, 1'b1, 4'h3, 4'b0010, 4'hB, 2'd1};
        tv[6]  = '{4'b0010, 4'b1101, 16'hFF3F, 1'b1, 4'b0010, 1'b0, 4'h3, 4'b0010, 4'hB, 2'd1};
        tv[7]  = '{4'b0010, 4'b0010, 16'hFF2F, 1'b0, 4'b0010, 1'b1, 4'h2, 4'b0000, 4'hB, 2'd1};
        tv[8]  = '{4'b0010, 4'b0010, 16'hFF2F, 1'b1, 4'b0010, 1'b1, 4'h2, 4'b0010, 4'hB, 2'd1};
        tv[9]  = '{4'b0000, 4'b0000, 16'hFF0F, 1'b0, 4'b0010, 1'b0, 4'h0, 4'b0000, 4'hB, 2'd1};
        tv[10] = '{4'b0000, 4'b1111, 16'hFFFF, 1'b1, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'hB, 2'd1};
        tv[11] = '{4'b0000, 4'b1111, 16'hFFFF, 1'b1, 4'b0000, 1'b0, 4'h0, 4'b0000, 4'hB, 2'd1};

        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        // Reset state, with every requester busy and valid
        #23;
        chk("rst grant",    32'(bus.grant),         'h0);
        chk("rst vld",      32'(bus.tras_cmd_vld),  'h0);
        chk("rst cmd",      32'(bus.tras_cmd),      'h0);
        chk("rst ready",    32'(bus.req_cmd_ready), 'h0);
        chk("rst mid",      32'(bus.curr_mid),      'h0);
        chk("rst pid",      32'(bus.curr_proc_id),  'h0);
        chk("rst hold_err", 32'(bus.hold_err),      'h0);

        @(posedge clock); #1;
        bus.req_busy = 4'h0; bus.req_cmd_vld = 4'h0; bus.tras_cmd_ready = 1'b0;
        rst_n = 1'b1;
        tick(); tick();

        // Single requester session from the table
        for (int i = 0; i < 12; i++) begin
            bus.req_busy       = tv[i].busy;
            bus.req_cmd_vld    = tv[i].vld;
            bus.req_cmd        = tv[i].cmd;
            bus.tras_cmd_ready = tv[i].rdy;
            #1;
            chk($sformatf("s1[%0d] grant", i), 32'(bus.grant),         32'(tv[i].e_grant));
            chk($sformatf("s1[%0d] vld", i),   32'(bus.tras_cmd_vld),  32'(tv[i].e_vld));
            chk($sformatf("s1[%0d] cmd", i),   32'(bus.tras_cmd),      32'(tv[i].e_cmd));
            chk($sformatf("s1[%0d] ready", i), 32'(bus.req_cmd_ready), 32'(tv[i].e_rr));
            chk($sformatf("s1[%0d] mid", i),   32'(bus.curr_mid),      32'(tv[i].e_mid));
            chk($sformatf("s1[%0d] pid", i),   32'(bus.curr_proc_id),  32'(tv[i].e_pid));
            chk($sformatf("s1[%0d] herr", i),  32'(bus.hold_err),      'h0);
            $display("vec %0d: busy=%b vld=%b rdy=%b -> grant=%b tvld=%b tcmd=%h",
                     i, tv[i].busy, tv[i].vld, tv[i].rdy, bus.grant, bus.tras_cmd_vld, bus.tras_cmd);
            @(posedge clock); #1;
        end

        // Reset while requester 3 owns the tap with a command pending
        bus.req_busy = 4'b1000; bus.req_cmd_vld = 4'b1000; bus.req_cmd = 16'h5000;
        bus.tras_cmd_ready = 1'b0;
        wait_grant(4'b1000, "s6 grant");
        chk("s6 vld before", 32'(bus.tras_cmd_vld), 'h1);
        chk("s6 cmd before", 32'(bus.tras_cmd),     'h5);
        chk("s6 mid before", 32'(bus.curr_mid),     'hD);
        bus.tras_cmd_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("s6 grant", 32'(bus.grant),         'h0);
        chk("s6 vld",   32'(bus.tras_cmd_vld),  'h0);
        chk("s6 cmd",   32'(bus.tras_cmd),      'h0);
        chk("s6 ready", 32'(bus.req_cmd_ready), 'h0);
        chk("s6 mid",   32'(bus.curr_mid),      'h0);
        chk("s6 pid",   32'(bus.curr_proc_id),  'h0);
        @(posedge clock); #1;
        rst_n = 1'b1;

        // Contention: all busy, each owner leaves after 3 handshakes
        bus.req_busy = 4'hF; bus.req_cmd_vld = 4'h0; bus.req_cmd = 16'h4321;
        bus.tras_cmd_ready = 1'b1;
        prev_g = 4'h0; zeros = 0; ngr = 0; hs = 0;
        for (int cyc = 0; cyc < 300 && ngr < 5; cyc++) begin
            g = bus.grant;
            if (g == 4'h0) begin
                zeros++;
                bus.req_busy = 4'hF; bus.req_cmd_vld = 4'h0;
            end else begin
                if (g != prev_g) begin
                    chk($sformatf("s2 grant#%0d", ngr), 32'(g), 32'(order[ngr]));
                    chk($sformatf("s2 mid#%0d", ngr), 32'(bus.curr_mid), 32'(10 + oh2idx(g)));
                    if (ngr > 0) chk($sformatf("s2 gap#%0d", ngr), 32'(zeros), 'd2);
                    ngr++; zeros = 0; hs = 0; prev_g = g;
                end
                if (hs < 3) begin
                    bus.req_busy = 4'hF; bus.req_cmd_vld = g;
                end else begin
                    bus.req_busy = 4'hF & ~g; bus.req_cmd_vld = 4'h0;
                end
            end
            #1;
            if (bus.tras_cmd_vld && bus.tras_cmd_ready) begin
                hs++;
                idx = oh2idx(g);
                chk("s2 cmd", 32'(bus.tras_cmd), 32'(idx + 1));
                $display("s2 handshake: owner=%0d cmd=%h", idx, bus.tras_cmd);
            end
            if (ngr < 5) begin
                @(posedge clock); #1;
            end
        end
        chk("s2 grants seen", 32'(ngr), 'd5);
        bus.req_busy = 4'h0; bus.req_cmd_vld = 4'h0;
        tick(); tick();

        // Wrap: owner 2 leaves rr_ptr at 3, then 0 and 2 both busy
        bus.req_busy = 4'b0100;
        wait_grant(4'b0100, "s3 first");
        bus.req_busy = 4'b0000;
        tick(); tick();
        bus.req_busy = 4'b0101;
        wait_grant(4'b0001, "s3 wrap");
        bus.req_busy = 4'b0100;
        tick();
        wait_grant(4'b0100, "s3 after");
        bus.req_busy = 4'b0000;
        tick(); tick();

        // Watchdog: owner 2 holds the tap without valid
        bus.req_busy = 4'b0100; bus.req_cmd_vld = 4'h0; bus.tras_cmd_ready = 1'b1;
        wait_grant(4'b0100, "s4 grant");
        repeat (15) tick();
        chk("s4 pre grant", 32'(bus.grant),    'h4);
        chk("s4 pre herr",  32'(bus.hold_err), 'h0);
        tick();
        chk("s4 herr",     32'(bus.hold_err), 'h1);
        chk("s4 released", 32'(bus.grant),    'h0);
        tick();
        chk("s4 herr once", 32'(bus.hold_err), 'h0);
        repeat (4) tick();
        chk("s4 lockout", 32'(bus.grant), 'h0);
        bus.req_busy = 4'b0110;
        wait_grant(4'b0010, "s4 other");
        bus.req_busy = 4'b0100;
        tick(); tick(); tick();
        chk("s4 still locked", 32'(bus.grant), 'h0);
        bus.req_busy = 4'b0000;
        tick();
        bus.req_busy = 4'b0100;
        wait_grant(4'b0100, "s4 regrant");
        bus.req_busy = 4'b0000;
        tick(); tick();

        // Boundary: busy fall coincides with watchdog terminal count
        bus.req_busy = 4'b0001; bus.req_cmd_vld = 4'h0;
        wait_grant(4'b0001, "s5 grant");
        repeat (15) tick();
        bus.req_busy = 4'b0000;
        tick();
        chk("s5 no herr", 32'(bus.hold_err), 'h0);
        chk("s5 rel",     32'(bus.grant),    'h0);
        bus.req_busy = 4'b0011;
        tick();
        chk("s5 rel wait", 32'(bus.grant), 'h0);
        tick();
        chk("s5 rr", 32'(bus.grant), 'h2);
        bus.req_busy = 4'b0000;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
